// File: rtl/solver_csr_bank_if.sv
// MMIO request/response bundle between the CCI-P MMIO path and the solver CSR bank.
// master : AFU-side MMIO path; drives read/write requests and receives read responses.
// slave  : the CSR bank; receives requests and returns registered read responses.
// Signals:
//   mmio_wr_valid / mmio_rd_valid : write / read strobes
//   mmio_addr  : 32-bit-word address; 64-bit registers sit at even addresses
//   mmio_tid   : read transaction ID, echoed on rsp_tid
//   mmio_wdata : write data
//   rsp_valid / rsp_tid / rsp_data : read response, one cycle after the read strobe
interface solver_csr_bank_if;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] mmio_addr;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wdata;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;

    modport master (
        output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
        input  rsp_valid, rsp_tid, rsp_data
    );

    modport slave (
        input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
        output rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/solver_csr_bank.sv
// MMIO register bank for NUM_CH independent ODE solver channels.
// Global registers: DFH, AFU_ID, DONE/BUSY bitmaps. Each channel has configuration
// registers, a CTRL command register, a STATUS register, captured results and an
// optional run-cycle counter.
//
// Optional feature macro: SOLVER_CSR_CYCLE_CNT_EN
//   defined   : per-channel 64-bit saturating CYCLES counters
//   undefined : no counter flops, CYCLES reads 0
//
// Ports:
//   clk, reset          : core clock, synchronous active-high reset
//   mmio                : MMIO request/response bundle (slave side)
//   o_ch_enb            : per-channel solver enable, high only while RUN
//   o_ch_h / o_ch_x_start / o_ch_y_start_val : 64-bit config, channel 0 in the LSBs
//   o_ch_n / o_ch_y_start_addr / o_ch_y_addr : 32-bit config, channel 0 in the LSBs
//   i_ch_fin            : solver finished
//   i_ch_x / i_ch_y_val : solver results, captured on completion
//
// Per-channel FSM:
//   state   | meaning
//   IDLE    | solver disabled, configuration writable
//   RUN     | solver enabled, configuration locked, CYCLES counting
//   DONE    | results captured, waiting for ACK or a new START
module solver_csr_bank #(
    parameter int unsigned  NUM_CH = 4,
    parameter logic [127:0] AFU_ID = 128'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    solver_csr_bank_if.slave        mmio,
    output logic [NUM_CH-1:0]       o_ch_enb,
    output logic [64*NUM_CH-1:0]    o_ch_h,
    output logic [64*NUM_CH-1:0]    o_ch_x_start,
    output logic [64*NUM_CH-1:0]    o_ch_y_start_val,
    output logic [32*NUM_CH-1:0]    o_ch_n,
    output logic [32*NUM_CH-1:0]    o_ch_y_start_addr,
    output logic [32*NUM_CH-1:0]    o_ch_y_addr,
    input  logic [NUM_CH-1:0]       i_ch_fin,
    input  logic [64*NUM_CH-1:0]    i_ch_x,
    input  logic [64*NUM_CH-1:0]    i_ch_y_val
);

    // AFU type in [63:60], end-of-list in bit 40
    localparam logic [63:0] DFH = 64'h1000_0100_0000_0000;

    localparam logic [4:0] OFF_H    = 5'h00;
    localparam logic [4:0] OFF_N    = 5'h02;
    localparam logic [4:0] OFF_XS   = 5'h04;
    localparam logic [4:0] OFF_YSA  = 5'h06;
    localparam logic [4:0] OFF_YSV  = 5'h08;
    localparam logic [4:0] OFF_YA   = 5'h0A;
    localparam logic [4:0] OFF_CTRL = 5'h0C;
    localparam logic [4:0] OFF_STAT = 5'h0E;
    localparam logic [4:0] OFF_X    = 5'h10;
    localparam logic [4:0] OFF_Y    = 5'h12;
    localparam logic [4:0] OFF_CYC  = 5'h14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state     [NUM_CH];
    state_t      w_state_nxt [NUM_CH];
    logic [63:0] r_h         [NUM_CH];
    logic [31:0] r_n         [NUM_CH];
    logic [63:0] r_xs        [NUM_CH];
    logic [31:0] r_ysa       [NUM_CH];
    logic [63:0] r_ysv       [NUM_CH];
    logic [31:0] r_ya        [NUM_CH];
    logic [63:0] r_x         [NUM_CH];
    logic [63:0] r_y         [NUM_CH];
    logic [63:0] w_cycles    [NUM_CH];
    logic [NUM_CH-1:0] r_err;

    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_cfg_wr;
    logic [NUM_CH-1:0] w_start;
    logic [NUM_CH-1:0] w_abort;
    logic [NUM_CH-1:0] w_ack;
    logic [NUM_CH-1:0] w_go;
    logic [NUM_CH-1:0] w_cap;
    logic [NUM_CH-1:0] w_err_set;
    logic [NUM_CH-1:0] w_done;
    logic [NUM_CH-1:0] w_busy;
    logic [4:0]        w_off;
    logic              w_ctrl_wr;
    logic              w_cfg_off;
    logic [63:0]       w_rd_data;

    logic              r_rsp_valid;
    logic [8:0]        r_rsp_tid;
    logic [63:0]       r_rsp_data;

    // Channel c occupies word addresses 0x20*(c+1) .. 0x20*(c+1)+0x1F
    assign w_off     = mmio.mmio_addr[4:0];
    assign w_ctrl_wr = mmio.mmio_wr_valid && (w_off == OFF_CTRL);
    assign w_cfg_off = w_off inside {OFF_H, OFF_N, OFF_XS, OFF_YSA, OFF_YSV, OFF_YA};

    // ABORT beats START beats ACK within a single CTRL write
    always_comb begin
        w_hit    = '0;
        w_cfg_wr = '0;
        w_start  = '0;
        w_abort  = '0;
        w_ack    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_hit[c]    = (mmio.mmio_addr[15:5] == 11'(c + 1));
            w_cfg_wr[c] = mmio.mmio_wr_valid && w_hit[c] && w_cfg_off;
            w_abort[c]  = w_ctrl_wr && w_hit[c] && mmio.mmio_wdata[1];
            w_start[c]  = w_ctrl_wr && w_hit[c] && mmio.mmio_wdata[0] && !mmio.mmio_wdata[1];
            w_ack[c]    = w_ctrl_wr && w_hit[c] && mmio.mmio_wdata[2]
                          && !mmio.mmio_wdata[1] && !mmio.mmio_wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) r_state[c] <= ST_IDLE;
        end else begin
            for (int c = 0; c < NUM_CH; c++) r_state[c] <= w_state_nxt[c];
        end
    end

    always_comb begin
        w_go      = '0;
        w_cap     = '0;
        w_err_set = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_state_nxt[c] = r_state[c];
            case (r_state[c])
                ST_IDLE: begin
                    if (w_start[c]) begin
                        w_state_nxt[c] = ST_RUN;
                        w_go[c]        = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_abort[c]) begin
                        w_state_nxt[c] = ST_IDLE;
                    end else if (i_ch_fin[c]) begin
                        w_state_nxt[c] = ST_DONE;
                        w_cap[c]       = 1'b1;
                    end
                    w_err_set[c] = w_start[c] || w_cfg_wr[c];
                end
                ST_DONE: begin
                    if (w_start[c]) begin
                        w_state_nxt[c] = ST_RUN;
                        w_go[c]        = 1'b1;
                    end else if (w_ack[c]) begin
                        w_state_nxt[c] = ST_IDLE;
                    end
                end
                default: w_state_nxt[c] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_h[c]   <= '0;
                r_n[c]   <= '0;
                r_xs[c]  <= '0;
                r_ysa[c] <= '0;
                r_ysv[c] <= '0;
                r_ya[c]  <= '0;
                r_x[c]   <= '0;
                r_y[c]   <= '0;
                r_err[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // Configuration is locked while the solver is consuming it
                if (w_cfg_wr[c] && (r_state[c] != ST_RUN)) begin
                    case (w_off)
                        OFF_H:   r_h[c]   <= mmio.mmio_wdata;
                        OFF_N:   r_n[c]   <= mmio.mmio_wdata[31:0];
                        OFF_XS:  r_xs[c]  <= mmio.mmio_wdata;
                        OFF_YSA: r_ysa[c] <= mmio.mmio_wdata[31:0];
                        OFF_YSV: r_ysv[c] <= mmio.mmio_wdata;
                        OFF_YA:  r_ya[c]  <= mmio.mmio_wdata[31:0];
                        default: ;
                    endcase
                end
                if (w_go[c]) begin
                    r_err[c] <= 1'b0;
                end else if (w_err_set[c]) begin
                    r_err[c] <= 1'b1;
                end
                if (w_cap[c]) begin
                    r_x[c] <= i_ch_x[c*64 +: 64];
                    r_y[c] <= i_ch_y_val[c*64 +: 64];
                end
            end
        end
    end

`ifdef SOLVER_CSR_CYCLE_CNT_EN
    logic [63:0] r_cycles [NUM_CH];

    // Counts every RUN cycle, including the one that moves to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) r_cycles[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_go[c]) begin
                    r_cycles[c] <= '0;
                end else if ((r_state[c] == ST_RUN) && (r_cycles[c] != '1)) begin
                    r_cycles[c] <= r_cycles[c] + 64'd1;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) w_cycles[c] = r_cycles[c];
    end
`else
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) w_cycles[c] = '0;
    end
`endif

    always_comb begin
        w_done            = '0;
        w_busy            = '0;
        o_ch_h            = '0;
        o_ch_n            = '0;
        o_ch_x_start      = '0;
        o_ch_y_start_addr = '0;
        o_ch_y_start_val  = '0;
        o_ch_y_addr       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_done[c]                   = (r_state[c] == ST_DONE);
            w_busy[c]                   = (r_state[c] == ST_RUN);
            o_ch_h[c*64 +: 64]          = r_h[c];
            o_ch_n[c*32 +: 32]          = r_n[c];
            o_ch_x_start[c*64 +: 64]    = r_xs[c];
            o_ch_y_start_addr[c*32 +: 32] = r_ysa[c];
            o_ch_y_start_val[c*64 +: 64] = r_ysv[c];
            o_ch_y_addr[c*32 +: 32]     = r_ya[c];
        end
    end

    assign o_ch_enb = w_busy;

    // Read mux works on current register values, so a same-cycle write is not visible
    always_comb begin
        w_rd_data = '0;
        case (mmio.mmio_addr)
            16'h0000: w_rd_data = DFH;
            16'h0002: w_rd_data = AFU_ID[63:0];
            16'h0004: w_rd_data = AFU_ID[127:64];
            16'h0010: w_rd_data[NUM_CH-1:0] = w_done;
            16'h0012: w_rd_data[NUM_CH-1:0] = w_busy;
            default: ;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_hit[c]) begin
                case (w_off)
                    OFF_H:    w_rd_data = r_h[c];
                    OFF_N:    w_rd_data = {32'h0, r_n[c]};
                    OFF_XS:   w_rd_data = r_xs[c];
                    OFF_YSA:  w_rd_data = {32'h0, r_ysa[c]};
                    OFF_YSV:  w_rd_data = r_ysv[c];
                    OFF_YA:   w_rd_data = {32'h0, r_ya[c]};
                    OFF_STAT: w_rd_data = {61'h0, r_err[c], r_state[c]};
                    OFF_X:    w_rd_data = r_x[c];
                    OFF_Y:    w_rd_data = r_y[c];
                    OFF_CYC:  w_rd_data = w_cycles[c];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_tid   <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= mmio.mmio_rd_valid;
            r_rsp_tid   <= mmio.mmio_tid;
            r_rsp_data  <= w_rd_data;
        end
    end

    assign mmio.rsp_valid = r_rsp_valid;
    assign mmio.rsp_tid   = r_rsp_tid;
    assign mmio.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_solver_csr_bank.sv
module tb_solver_csr_bank;

    localparam int           NUM_CH = 4;
    localparam logic [127:0] AFU_ID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [63:0]  DFH    = 64'h1000_0100_0000_0000;
`ifdef SOLVER_CSR_CYCLE_CNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [3:0]   ch_enb;
    logic [255:0] ch_h, ch_xs, ch_ysv, ch_x, ch_yv;
    logic [127:0] ch_n, ch_ysa, ch_ya;
    logic [3:0]   ch_fin;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain per-channel records updated once per clock edge
    int          m_state [NUM_CH];   // 0 idle, 1 run, 2 done
    bit          m_err   [NUM_CH];
    logic [63:0] m_cfg   [NUM_CH][6]; // H, N, X_START, Y_START_ADDR, Y_START_VAL, Y_ADDR
    logic [63:0] m_x     [NUM_CH];
    logic [63:0] m_y     [NUM_CH];
    logic [63:0] m_cyc   [NUM_CH];
    bit          m_rsp_valid;
    logic [8:0]  m_rsp_tid;
    logic [63:0] m_rsp_data;

    solver_csr_bank_if bus ();

    solver_csr_bank #(.NUM_CH(NUM_CH), .AFU_ID(AFU_ID)) dut (
        .clk               (clk),
        .reset             (reset),
        .mmio              (bus.slave),
        .o_ch_enb          (ch_enb),
        .o_ch_h            (ch_h),
        .o_ch_x_start      (ch_xs),
        .o_ch_y_start_val  (ch_ysv),
        .o_ch_n            (ch_n),
        .o_ch_y_start_addr (ch_ysa),
        .o_ch_y_addr       (ch_ya),
        .i_ch_fin          (ch_fin),
        .i_ch_x            (ch_x),
        .i_ch_y_val        (ch_yv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [15:0] a);
        int ai, c, off;
        logic [63:0] v;
        ai = int'(a);
        v  = '0;
        if (ai == 0) v = DFH;
        else if (ai == 2) v = AFU_ID[63:0];
        else if (ai == 4) v = AFU_ID[127:64];
        else if (ai == 16 || ai == 18) begin
            for (int k = 0; k < NUM_CH; k++)
                if (m_state[k] == ((ai == 16) ? 2 : 1)) v[k] = 1'b1;
        end else if (ai >= 32) begin
            c   = (ai - 32) / 32;
            off = (ai - 32) % 32;
            if (c < NUM_CH) begin
                if (off <= 10 && off % 2 == 0) v = m_cfg[c][off / 2];
                else if (off == 14) v = 64'(m_state[c]) | (m_err[c] ? 64'd4 : 64'd0);
                else if (off == 16) v = m_x[c];
                else if (off == 18) v = m_y[c];
                else if (off == 20) v = CYC_EN ? m_cyc[c] : 64'd0;
            end
        end
        return v;
    endfunction

    task automatic model_edge();
        int wc, woff, k;
        bit start, abort, ack, cfg;
        if (reset) begin
            m_rsp_valid = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_state[c] = 0; m_err[c] = 1'b0;
                m_x[c] = '0; m_y[c] = '0; m_cyc[c] = '0;
                for (int j = 0; j < 6; j++) m_cfg[c][j] = '0;
            end
            return;
        end
        m_rsp_valid = bus.mmio_rd_valid;
        m_rsp_tid   = bus.mmio_tid;
        m_rsp_data  = model_read(bus.mmio_addr);
        wc = -1; woff = -1;
        if (bus.mmio_wr_valid && int'(bus.mmio_addr) >= 32) begin
            wc   = (int'(bus.mmio_addr) - 32) / 32;
            woff = (int'(bus.mmio_addr) - 32) % 32;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            start = 0; abort = 0; ack = 0; cfg = 0; k = 0;
            if (wc == c && woff == 12) begin
                abort = bus.mmio_wdata[1];
                start = bus.mmio_wdata[0] && !abort;
                ack   = bus.mmio_wdata[2] && !abort && !start;
            end
            if (wc == c && woff <= 10 && woff % 2 == 0) begin
                cfg = 1; k = woff / 2;
            end
            if (m_state[c] == 1) begin
                if (m_cyc[c] != 64'hFFFF_FFFF_FFFF_FFFF) m_cyc[c] = m_cyc[c] + 1;
                if (start || cfg) m_err[c] = 1'b1;
                if (abort) m_state[c] = 0;
                else if (ch_fin[c]) begin
                    m_state[c] = 2;
                    m_x[c] = ch_x[c*64 +: 64];
                    m_y[c] = ch_yv[c*64 +: 64];
                end
            end else begin
                if (cfg) m_cfg[c][k] = (k % 2 == 1) ? {32'h0, bus.mmio_wdata[31:0]} : bus.mmio_wdata;
                if (start) begin
                    m_state[c] = 1; m_cyc[c] = '0; m_err[c] = 1'b0;
                end else if (ack && m_state[c] == 2) m_state[c] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [255:0] eh, exs, eysv;
        logic [127:0] en, eysa, eya;
        logic [3:0]   enb;
        for (int c = 0; c < NUM_CH; c++) begin
            eh[c*64 +: 64]   = m_cfg[c][0];
            en[c*32 +: 32]   = m_cfg[c][1][31:0];
            exs[c*64 +: 64]  = m_cfg[c][2];
            eysa[c*32 +: 32] = m_cfg[c][3][31:0];
            eysv[c*64 +: 64] = m_cfg[c][4];
            eya[c*32 +: 32]  = m_cfg[c][5][31:0];
            enb[c]           = (m_state[c] == 1);
        end
        chk("rsp_valid", 256'(bus.rsp_valid), 256'(m_rsp_valid));
        if (m_rsp_valid) begin
            chk("rsp_tid", 256'(bus.rsp_tid), 256'(m_rsp_tid));
            chk("rsp_data", 256'(bus.rsp_data), 256'(m_rsp_data));
        end
        chk("ch_enb", 256'(ch_enb), 256'(enb));
        chk("ch_h", ch_h, eh);
        chk("ch_n", 256'(ch_n), 256'(en));
        chk("ch_x_start", ch_xs, exs);
        chk("ch_y_start_addr", 256'(ch_ysa), 256'(eysa));
        chk("ch_y_start_val", ch_ysv, eysv);
        chk("ch_y_addr", 256'(ch_ya), 256'(eya));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        bus.mmio_wr_valid = 1'b1;
        bus.mmio_addr     = a;
        bus.mmio_wdata    = d;
        step();
        bus.mmio_wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [8:0] tid, input logic [63:0] exp, input string tag);
        bus.mmio_rd_valid = 1'b1;
        bus.mmio_addr     = a;
        bus.mmio_tid      = tid;
        step();
        bus.mmio_rd_valid = 1'b0;
        chk({tag, "_valid"}, 256'(bus.rsp_valid), 256'(1));
        chk({tag, "_tid"}, 256'(bus.rsp_tid), 256'(tid));
        chk(tag, 256'(bus.rsp_data), 256'(exp));
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] g [9];
        g = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008,
              16'h0010, 16'h0012, 16'h0014, 16'h0021};
        if ($urandom_range(0, 9) < 2) return g[$urandom_range(0, 8)];
        return 16'(32 + 32 * $urandom_range(0, NUM_CH) + 2 * $urandom_range(0, 11));
    endfunction

    initial begin
        reset = 1'b1;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        bus.mmio_addr     = '0;
        bus.mmio_tid      = '0;
        bus.mmio_wdata    = '0;
        ch_fin = '0;
        ch_x   = '0;
        ch_yv  = '0;
        idle(3);
        reset = 1'b0;
        chk("reset_enb", 256'(ch_enb), 256'(0));
        chk("reset_rsp_valid", 256'(bus.rsp_valid), 256'(0));

        rd(16'h0000, 9'h05, DFH, "dfh");
        rd(16'h0002, 9'h11, AFU_ID[63:0], "afu_id_l");
        rd(16'h0004, 9'h12, AFU_ID[127:64], "afu_id_h");
        rd(16'h0006, 9'h13, 64'h0, "rsvd6");

        wr(16'h0040, 64'h3F50_0000_0000_0000);
        wr(16'h004C, 64'h1);
        chk("ch1_enb", 256'(ch_enb), 256'(4'b0010));
        chk("ch1_h", 256'(ch_h[127:64]), 256'(64'h3F50_0000_0000_0000));
        rd(16'h0012, 9'h20, 64'h2, "busy");
        idle(9);
        ch_fin[1] = 1'b1;
        ch_x[127:64] = 64'h1234;
        step();
        ch_fin = '0;
        ch_x   = '0;
        chk("ch1_enb_done", 256'(ch_enb[1]), 256'(0));
        rd(16'h004E, 9'h21, 64'h2, "ch1_status");
        rd(16'h0050, 9'h22, 64'h1234, "ch1_x");
        rd(16'h0010, 9'h23, 64'h2, "done");
        rd(16'h0054, 9'h24, CYC_EN ? 64'd11 : 64'd0, "ch1_cycles");
        wr(16'h004C, 64'h4);
        rd(16'h004E, 9'h25, 64'h0, "ch1_ack_status");

        wr(16'h002C, 64'h1);
        wr(16'h0022, 64'h7);
        wr(16'h002C, 64'h1);
        rd(16'h0022, 9'h30, 64'h0, "ch0_n_locked");
        rd(16'h002E, 9'h31, 64'h5, "ch0_status_err");
        chk("ch0_enb", 256'(ch_enb[0]), 256'(1));

        wr(16'h006C, 64'h1);
        ch_fin[2] = 1'b1;
        ch_x[191:128] = 64'hDEAD;
        wr(16'h006C, 64'h2);
        ch_fin = '0;
        ch_x   = '0;
        chk("ch2_enb_abort", 256'(ch_enb[2]), 256'(0));
        rd(16'h006E, 9'h40, 64'h0, "ch2_status");
        rd(16'h0070, 9'h41, 64'h0, "ch2_x");

        wr(16'h0080, 64'h55);
        bus.mmio_wr_valid = 1'b1;
        bus.mmio_rd_valid = 1'b1;
        bus.mmio_addr     = 16'h0080;
        bus.mmio_wdata    = 64'hAA;
        bus.mmio_tid      = 9'h50;
        step();
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        chk("rd_wr_same", 256'(bus.rsp_data), 256'(64'h55));
        rd(16'h0080, 9'h51, 64'hAA, "ch3_h_new");

        wr(16'h00A0, 64'hFFFF);
        rd(16'h00A0, 9'h60, 64'h0, "unmapped_ch4");

        bus.mmio_rd_valid = 1'b1;
        bus.mmio_addr     = 16'h002E;
        bus.mmio_tid      = 9'h70;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        chk("reset_drop_rsp", 256'(bus.rsp_valid), 256'(0));
        chk("reset_enb_mid", 256'(ch_enb), 256'(0));
        rd(16'h002E, 9'h71, 64'h0, "ch0_status_post_reset");

        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            bus.mmio_wr_valid = 1'b0;
            bus.mmio_rd_valid = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                bus.mmio_wr_valid = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    bus.mmio_addr  = 16'(32 + 32 * $urandom_range(0, NUM_CH - 1) + 12);
                    bus.mmio_wdata = 64'($urandom_range(0, 7));
                end else begin
                    bus.mmio_addr  = rand_addr();
                    bus.mmio_wdata = {$urandom, $urandom};
                end
            end
            if ($urandom_range(0, 1) == 0) begin
                bus.mmio_rd_valid = 1'b1;
                bus.mmio_tid      = 9'($urandom_range(0, 511));
                if (!bus.mmio_wr_valid) bus.mmio_addr = rand_addr();
            end
            for (int c = 0; c < NUM_CH; c++) ch_fin[c] = ($urandom_range(0, 4) == 0);
            ch_x  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ch_yv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step();
        end
        reset = 1'b0;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        ch_fin = '0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
